fetch_unit: RTL and testbench

Instruction fetch stage feeding the pipelined processor core. It owns the program counter and issues word fetches to instruction memory over a valid/ready request channel with one request outstanding at a time. Returned instructions are buffered with their PC in a small FIFO and presented to decode through a valid/ready handshake. A redirect input from execute (branch/jump) flushes the buffer and cancels or discards any in-flight fetch.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word fetch at a time,
// buffers returned instructions with their PC and hands them to decode; redirects flush everything.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_instr_o,
  output logic [31:0] dec_pc_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {REQ, WAIT, DISCARD} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pcInflight_q, pcInflight_d;
  logic [31:0]   instrMem_q [FIFO_DEPTH];
  logic [31:0]   pcMem_q    [FIFO_DEPTH];
  logic [AW-1:0] rdPtr_q, wrPtr_q;
  logic [CW-1:0] count_q;

  logic fifoEmpty, fifoFull;
  logic reqValid, push, pop, decValid;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == DEPTH_C);
  assign decValid  = !fifoEmpty && !redirect_i;
  assign pop       = decValid && dec_ready_i;

  // DISCARD remembers that the outstanding response belongs to a flushed stream.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pcInflight_d = pcInflight_q;
    reqValid     = 1'b0;
    push         = 1'b0;
    case (state_q)
      REQ: begin
        reqValid = !fifoFull && !redirect_i;
        if (reqValid && imem_req_ready_i) begin
          pcInflight_d = pc_q;
          pc_d         = pc_q + 32'd4;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid_i) begin
          push    = !redirect_i;
          state_d = REQ;
        end else if (redirect_i) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_resp_valid_i) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
    if (redirect_i) pc_d = redirect_pc_i & 32'hFFFF_FFFC;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      pcInflight_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pcInflight_q <= pcInflight_d;
    end
  end

  // Storage is zeroed on reset so the empty buffer presents zeros to decode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instrMem_q[i] <= '0;
        pcMem_q[i]    <= '0;
      end
    end else if (redirect_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        instrMem_q[wrPtr_q] <= imem_resp_data_i;
        pcMem_q[wrPtr_q]    <= pcInflight_q;
        wrPtr_q             <= wrPtr_q + AW'(1);
      end
      if (pop) rdPtr_q <= rdPtr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign imem_req_valid_o = reqValid;
  assign imem_req_addr_o  = pc_q;
  assign dec_valid_o      = decValid;
  assign dec_instr_o      = instrMem_q[rdPtr_q];
  assign dec_pc_o         = pcMem_q[rdPtr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed cycle table, hand-written wrap/reset sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i), .imem_resp_data_i(imem_resp_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ready;
    logic        respValid;
    logic [31:0] respData;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        decReady;
    logic        expReqValid;
    logic [31:0] expReqAddr;
    logic        expDecValid;
    logic [31:0] expDecPc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int vectors = 0;
  int miscompares = 0;
  vec_t tbl [26];

  ent_t        mq[$];
  logic [31:0] mPc, mOutPc, memAddr;
  bit          mOut, mStale, memPending, memResp, expReq, expDec;
  int          memWait;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hA5A5_5A5A;
  endfunction

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rd,
                              input logic red, input logic [31:0] rpc, input logic dr,
                              input logic eq, input logic [31:0] ea,
                              input logic ed, input logic [31:0] ep);
    vec_t v;
    v.ready = r; v.respValid = rv; v.respData = rd; v.redirect = red;
    v.redirectPc = rpc; v.decReady = dr; v.expReqValid = eq; v.expReqAddr = ea;
    v.expDecValid = ed; v.expDecPc = ep;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    imem_req_ready_i  = v.ready;
    imem_resp_valid_i = v.respValid;
    imem_resp_data_i  = v.respData;
    redirect_i        = v.redirect;
    redirect_pc_i     = v.redirectPc;
    dec_ready_i       = v.decReady;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkVec(input string tag, input vec_t v);
    checkOutput({tag, " req_valid"}, 32'(imem_req_valid_o), 32'(v.expReqValid));
    if (v.expReqValid) checkOutput({tag, " req_addr"}, imem_req_addr_o, v.expReqAddr);
    checkOutput({tag, " dec_valid"}, 32'(dec_valid_o), 32'(v.expDecValid));
    if (v.expDecValid) begin
      checkOutput({tag, " dec_pc"}, dec_pc_o, v.expDecPc);
      checkOutput({tag, " dec_instr"}, dec_instr_o, memWord(v.expDecPc));
    end
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_i = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0,                 0, 0,          1, 1, 32'h0,   0, 0);
    tbl[1]  = mk(1, 1, memWord(32'h0),    0, 0,          1, 0, 0,       0, 0);
    tbl[2]  = mk(1, 0, 0,                 0, 0,          1, 1, 32'h4,   1, 32'h0);
    tbl[3]  = mk(1, 1, memWord(32'h4),    0, 0,          1, 0, 0,       0, 0);
    tbl[4]  = mk(1, 0, 0,                 0, 0,          1, 1, 32'h8,   1, 32'h4);
    tbl[5]  = mk(1, 1, memWord(32'h8),    0, 0,          1, 0, 0,       0, 0);
    tbl[6]  = mk(1, 0, 0,                 0, 0,          1, 1, 32'hC,   1, 32'h8);
    tbl[7]  = mk(1, 1, memWord(32'hC),    0, 0,          0, 0, 0,       0, 0);
    tbl[8]  = mk(1, 0, 0,                 0, 0,          0, 1, 32'h10,  1, 32'hC);
    tbl[9]  = mk(1, 1, memWord(32'h10),   0, 0,          0, 0, 0,       1, 32'hC);
    tbl[10] = mk(1, 0, 0,                 0, 0,          0, 0, 0,       1, 32'hC);
    tbl[11] = mk(1, 0, 0,                 0, 0,          0, 0, 0,       1, 32'hC);
    tbl[12] = mk(1, 0, 0,                 0, 0,          1, 0, 0,       1, 32'hC);
    tbl[13] = mk(1, 0, 0,                 0, 0,          0, 1, 32'h14,  1, 32'h10);
    tbl[14] = mk(1, 1, memWord(32'h14),   1, 32'h203,    0, 0, 0,       0, 0);
    tbl[15] = mk(0, 0, 0,                 0, 0,          0, 1, 32'h200, 0, 0);
    tbl[16] = mk(1, 0, 0,                 0, 0,          0, 1, 32'h200, 0, 0);
    tbl[17] = mk(1, 0, 0,                 1, 32'h103,    0, 0, 0,       0, 0);
    tbl[18] = mk(1, 0, 0,                 0, 0,          0, 0, 0,       0, 0);
    tbl[19] = mk(1, 1, 32'hDEAD_BEEF,     0, 0,          0, 0, 0,       0, 0);
    tbl[20] = mk(1, 0, 0,                 0, 0,          0, 1, 32'h100, 0, 0);
    tbl[21] = mk(1, 1, memWord(32'h100),  0, 0,          0, 0, 0,       0, 0);
    tbl[22] = mk(1, 0, 0,                 0, 0,          0, 1, 32'h104, 1, 32'h100);
    tbl[23] = mk(1, 1, memWord(32'h104),  0, 0,          0, 0, 0,       1, 32'h100);
    tbl[24] = mk(1, 0, 0,                 1, 32'h300,    1, 0, 0,       0, 0);
    tbl[25] = mk(0, 0, 0,                 0, 0,          0, 1, 32'h300, 0, 0);

    rst_i = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk_i);
    #2;
    checkOutput("reset req_valid", 32'(imem_req_valid_o), 32'd1);
    checkOutput("reset req_addr", imem_req_addr_o, 32'h0);
    checkOutput("reset dec_valid", 32'(dec_valid_o), 32'd0);
    checkOutput("reset dec_instr", dec_instr_o, 32'h0);
    checkOutput("reset dec_pc", dec_pc_o, 32'h0);
    rst_i = 1'b0;

    for (int i = 0; i < 26; i++) begin
      @(negedge clk_i);
      applyStimulus(tbl[i]);
      #2;
      checkVec($sformatf("row%0d", i), tbl[i]);
    end

    // PC wrap from the top of the address space.
    @(negedge clk_i);
    applyStimulus(mk(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0));
    #2 checkOutput("wrap redirect req_valid", 32'(imem_req_valid_o), 32'd0);
    @(negedge clk_i);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 checkVec("wrap req", mk(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0));
    @(negedge clk_i);
    applyStimulus(mk(0, 1, memWord(32'hFFFF_FFFC), 0, 0, 0, 0, 0, 0, 0));
    #2 checkOutput("wrap resp dec_valid", 32'(dec_valid_o), 32'd0);
    @(negedge clk_i);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 checkVec("wrap next", mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFFC));

    // Reset while a fetch is outstanding; the late response must be ignored.
    @(negedge clk_i);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 checkVec("rstwait req", mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFFC));
    @(negedge clk_i);
    rst_i = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 checkVec("rstwait in reset", mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(mk(0, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0));
    #2 checkVec("rstwait late resp", mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    @(negedge clk_i);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 checkVec("rstwait after", mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));

    // Randomized traffic against the reference model.
    doReset();
    mq.delete();
    mPc = 32'h0; mOut = 0; mStale = 0; mOutPc = 0;
    memPending = 0; memWait = 0; memAddr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      memResp           = memPending && (memWait == 0);
      imem_resp_valid_i = memResp;
      imem_resp_data_i  = memResp ? memWord(memAddr) : $urandom;
      imem_req_ready_i  = !memPending && ($urandom_range(0, 3) != 0);
      redirect_i        = ($urandom_range(0, 15) == 0);
      redirect_pc_i     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
      dec_ready_i       = ($urandom_range(0, 2) != 0);
      #2;
      expReq = !mOut && (mq.size() < DEPTH) && !redirect_i;
      expDec = (mq.size() > 0) && !redirect_i;
      checkOutput("rand req_valid", 32'(imem_req_valid_o), 32'(expReq));
      if (expReq) checkOutput("rand req_addr", imem_req_addr_o, mPc);
      checkOutput("rand dec_valid", 32'(dec_valid_o), 32'(expDec));
      if (expDec) begin
        checkOutput("rand dec_pc", dec_pc_o, mq[0].pc);
        checkOutput("rand dec_instr", dec_instr_o, mq[0].instr);
      end

      if (memPending) begin
        if (memWait == 0) memPending = 0;
        else memWait--;
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        memPending = 1;
        memAddr    = imem_req_addr_o;
        memWait    = $urandom_range(0, 2);
      end

      if (expDec && dec_ready_i) void'(mq.pop_front());
      if (memResp && mOut) begin
        if (!redirect_i && !mStale) mq.push_back('{pc: mOutPc, instr: memWord(mOutPc)});
        mOut = 0;
      end
      if (expReq && imem_req_ready_i) begin
        mOut   = 1;
        mStale = 0;
        mOutPc = mPc;
        mPc    = mPc + 32'd4;
      end
      if (redirect_i) begin
        mq.delete();
        if (mOut) mStale = 1;
        mPc = redirect_pc_i & 32'hFFFF_FFFC;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
